// File: rtl/neuron_scheduler.sv
// Sequences one fully-connected inference pass: collect an input vector, stream
// (input, weight) pairs into the shared MAC per neuron, saturate and transmit each result.
module neuron_scheduler #(
    parameter int N_NEURONS = 4,
    parameter int N_INPUTS  = 16,
    parameter int ADDR_W    = 8,
    parameter int ACC_W     = 20,
    parameter int SHIFT     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              weights_ready,
    input  logic              rx_done,
    input  logic [7:0]        rx_data,
    output logic [ADDR_W-1:0] w_rd_addr,
    input  logic [7:0]        w_rd_data,
    output logic              mac_clear,
    output logic              mac_valid,
    output logic [7:0]        mac_a,
    output logic [7:0]        mac_b,
    input  logic [ACC_W-1:0]  mac_acc,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic              busy,
    output logic              frame_done,
    output logic              rx_overrun,
    output logic [2:0]        dbg_state
);

    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int N_W   = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-128);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_CLEAR   = 3'd2,
        S_ISSUE   = 3'd3,
        S_DRAIN   = 3'd4,
        S_LATCH   = 3'd5,
        S_SEND    = 3'd6,
        S_GAP     = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] i_q, i_d;
    logic [N_W-1:0]   n_q, n_d;
    logic [7:0]       a_q, a_d;
    logic             valid_q, valid_d;
    logic [7:0]       tx_q, tx_d;
    logic             ovr_q, ovr_d;
    logic [7:0]       in_buf_q [N_INPUTS];

    logic                    cnt_last, i_last, n_last;
    logic signed [ACC_W-1:0] shifted;
    logic [7:0]              sat;

    assign cnt_last = (cnt_q == CNT_W'(N_INPUTS - 1));
    assign i_last   = (i_q == CNT_W'(N_INPUTS - 1));
    assign n_last   = (n_q == N_W'(N_NEURONS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (weights_ready) state_d = S_COLLECT;
            S_COLLECT: if (rx_done && cnt_last) state_d = S_CLEAR;
            S_CLEAR:   state_d = S_ISSUE;
            S_ISSUE:   if (i_last) state_d = S_DRAIN;
            S_DRAIN:   state_d = S_LATCH;
            S_LATCH:   state_d = S_SEND;
            S_SEND:    if (!tx_busy) state_d = S_GAP;
            S_GAP:     state_d = n_last ? S_COLLECT : S_CLEAR;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mac_clear  = (state_q == S_CLEAR);
        tx_start   = (state_q == S_SEND) && !tx_busy;
        frame_done = (state_q == S_GAP) && n_last;
        busy       = (state_q != S_IDLE) && (state_q != S_COLLECT);
    end

    // Accumulator is read in LATCH, after the final mac_valid has been absorbed.
    assign shifted = $signed(mac_acc) >>> SHIFT;

    always_comb begin
        if (shifted > SAT_MAX) begin
            sat = 8'h7F;
        end else if (shifted < SAT_MIN) begin
            sat = 8'h80;
        end else begin
            sat = shifted[7:0];
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        i_d     = i_q;
        n_d     = n_q;
        a_d     = a_q;
        valid_d = 1'b0;
        tx_d    = tx_q;
        ovr_d   = ovr_q | (rx_done & busy);
        case (state_q)
            S_COLLECT: begin
                if (rx_done) begin
                    cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
                    if (cnt_last) n_d = '0;
                end
            end
            S_CLEAR: i_d = '0;
            S_ISSUE: begin
                // Operand a is delayed one cycle to line up with the RAM read latency.
                valid_d = 1'b1;
                a_d     = in_buf_q[i_q];
                i_d     = i_last ? '0 : i_q + 1'b1;
            end
            S_LATCH: tx_d = sat;
            S_GAP: begin
                if (n_last) begin
                    cnt_d = '0;
                end else begin
                    n_d = n_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            i_q     <= '0;
            n_q     <= '0;
            a_q     <= '0;
            valid_q <= 1'b0;
            tx_q    <= '0;
            ovr_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            i_q     <= i_d;
            n_q     <= n_d;
            a_q     <= a_d;
            valid_q <= valid_d;
            tx_q    <= tx_d;
            ovr_q   <= ovr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_COLLECT && rx_done) begin
            in_buf_q[cnt_q] <= rx_data;
        end
    end

    assign w_rd_addr  = ADDR_W'(n_q) * ADDR_W'(N_INPUTS) + ADDR_W'(i_q);
    assign mac_valid  = valid_q;
    assign mac_a      = valid_q ? a_q : 8'h00;
    assign mac_b      = valid_q ? w_rd_data : 8'h00;
    assign tx_data    = tx_q;
    assign rx_overrun = ovr_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_neuron_scheduler.sv
// Bench for neuron_scheduler: weight RAM and MAC models around the DUT, table-driven
// frames, a tx scoreboard and hand-written back-pressure / overrun / reset sequences.
module tb_neuron_scheduler;

    localparam int NI = 16;
    localparam int NN = 4;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_LATCH = 3'd5;
    localparam logic [2:0] S_SEND  = 3'd6;

    logic              clk = 1'b0;
    logic              reset;
    logic              weights_ready;
    logic              rx_done;
    logic [7:0]        rx_data;
    logic [7:0]        w_rd_addr;
    logic [7:0]        w_rd_data;
    logic              mac_clear;
    logic              mac_valid;
    logic [7:0]        mac_a;
    logic [7:0]        mac_b;
    logic signed [19:0] mac_acc;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy;
    logic              busy;
    logic              frame_done;
    logic              rx_overrun;
    logic [2:0]        dbg_state;

    neuron_scheduler dut (
        .clk(clk), .reset(reset), .weights_ready(weights_ready),
        .rx_done(rx_done), .rx_data(rx_data),
        .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
        .mac_clear(mac_clear), .mac_valid(mac_valid), .mac_a(mac_a), .mac_b(mac_b),
        .mac_acc(mac_acc),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .busy(busy), .frame_done(frame_done), .rx_overrun(rx_overrun),
        .dbg_state(dbg_state)
    );

    // Clock / reset environment, weight RAM and MAC models
    always #5 clk = ~clk;

    logic [7:0] wmem [256];
    always @(posedge clk) w_rd_data <= wmem[w_rd_addr];

    always @(posedge clk or posedge reset) begin
        if (reset) mac_acc <= '0;
        else if (mac_clear) mac_acc <= '0;
        else if (mac_valid) mac_acc <= mac_acc + ($signed(mac_a) * $signed(mac_b));
    end

    logic [40:0] all_outs;
    assign all_outs = {w_rd_addr, mac_clear, mac_valid, mac_a, mac_b, tx_start,
                       tx_data, busy, frame_done, rx_overrun, dbg_state};

    // Scoreboard and counters
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] cur_in [NI];

    int cyc = 0;
    int last_rx_cyc = 0, clear_cyc = 0, last_start_cyc = 0;
    int valid_cnt = 0, clear_cnt = 0, starts_in_frame = 0, start_total = 0;
    int frames = 0, mac_act = 0;
    bit clear_seen = 0, bp_skip = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            check("clear_valid_exclusive", {63'd0, mac_clear & mac_valid}, 64'd0);
            check("start_while_busy", {63'd0, tx_start & tx_busy}, 64'd0);
            if (rx_done) last_rx_cyc = cyc;
            if (mac_clear || mac_valid) mac_act++;
            if (mac_clear) begin
                if (!clear_seen) check("last_rx_to_clear", 64'(cyc - last_rx_cyc), 64'd1);
                clear_seen = 1;
                clear_cyc  = cyc;
                valid_cnt  = 0;
                clear_cnt++;
            end
            if (mac_valid) valid_cnt++;
            if (tx_start) begin
                check("valid_per_neuron", 64'(valid_cnt), 64'(NI));
                if (bp_skip) bp_skip = 0;
                else check("clear_to_start", 64'(cyc - clear_cyc), 64'(NI + 3));
                if (exp_q.size() == 0) check("unexpected_tx", 64'd1, 64'd0);
                else check("tx_data", {56'd0, tx_data}, {56'd0, exp_q.pop_front()});
                last_start_cyc = cyc;
                starts_in_frame++;
                start_total++;
            end
            if (frame_done) begin
                check("frame_done_latency", 64'(cyc - last_start_cyc), 64'd1);
                check("starts_per_frame", 64'(starts_in_frame), 64'(NN));
                frames++;
                starts_in_frame = 0;
                clear_seen = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus table
    typedef struct {
        logic [7:0] in0;
        logic [7:0] in_rest;
        logic [7:0] w [NN];
        logic [7:0] e [NN];
    } vec_t;
    vec_t vecs [4];

    function automatic vec_t mk(int in0, int rest, int w0, int w1, int w2, int w3,
                                int e0, int e1, int e2, int e3);
        vec_t v;
        v.in0 = 8'(in0);  v.in_rest = 8'(rest);
        v.w[0] = 8'(w0);  v.w[1] = 8'(w1);  v.w[2] = 8'(w2);  v.w[3] = 8'(w3);
        v.e[0] = 8'(e0);  v.e[1] = 8'(e1);  v.e[2] = 8'(e2);  v.e[3] = 8'(e3);
        return v;
    endfunction

    function automatic logic [7:0] golden(int k);
        int acc = 0;
        int r;
        for (int j = 0; j < NI; j++)
            acc += int'($signed(cur_in[j])) * int'($signed(wmem[k * NI + j]));
        r = acc >>> 4;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return 8'(r);
    endfunction

    // Driver tasks
    task automatic send_byte(input logic [7:0] b);
        int gap;
        rx_done = 1'b1;
        rx_data = b;
        @(posedge clk); #1;
        rx_done = 1'b0;
        gap = $urandom_range(0, 2);
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic drive_frame();
        for (int j = 0; j < NI; j++) send_byte(cur_in[j]);
    endtask

    task automatic load_vec(input int idx);
        for (int k = 0; k < NN; k++)
            for (int j = 0; j < NI; j++) wmem[k * NI + j] = vecs[idx].w[k];
        for (int j = 0; j < NI; j++) cur_in[j] = (j == 0) ? vecs[idx].in0 : vecs[idx].in_rest;
        for (int k = 0; k < NN; k++) exp_q.push_back(vecs[idx].e[k]);
    endtask

    task automatic wait_frame(input string name);
        int f0 = frames;
        int n = 0;
        while (frames == f0 && n < 2000) begin @(posedge clk); #1; n++; end
        if (frames == f0) check({name, "_frame_timeout"}, 64'd0, 64'd1);
        check({name, "_exp_q_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_state(input string name, input logic [2:0] s, input int min_clears);
        int n = 0;
        while (!(dbg_state == s && clear_cnt >= min_clears) && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 2000) check({name, "_wait_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        int base, st;
        reset = 1'b1; weights_ready = 1'b0; rx_done = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
        for (int a = 0; a < 256; a++) wmem[a] = 8'h00;
        vecs[0] = mk(1, 1,     1, 2, 3, 4,          1, 2, 3, 4);
        vecs[1] = mk(127, 127, 127, -128, 1, -1,    127, -128, 127, -127);
        vecs[2] = mk(-17, 0,   1, -1, 2, 0,         -2, 1, -3, 0);
        vecs[3] = mk(8, 8,     8, -8, 16, -16,      64, -64, 127, -128);

        repeat (3) @(posedge clk); #1;
        check("reset_outputs", {23'd0, all_outs}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Gating: bytes ignored while weights are not ready
        for (int j = 0; j < NI; j++) send_byte(8'($urandom_range(0, 255)));
        @(negedge clk);
        check("gate_state_idle", {61'd0, dbg_state}, {61'd0, S_IDLE});
        check("gate_no_mac", 64'(mac_act), 64'd0);
        check("gate_no_overrun", {63'd0, rx_overrun}, 64'd0);
        check("gate_not_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        weights_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        for (int v = 0; v < 4; v++) begin
            load_vec(v);
            drive_frame();
            wait_frame($sformatf("vec%0d", v));
        end

        for (int r = 0; r < 2; r++) begin
            for (int a = 0; a < NN * NI; a++) wmem[a] = 8'($urandom_range(0, 255));
            for (int j = 0; j < NI; j++) cur_in[j] = 8'($urandom_range(0, 255));
            for (int k = 0; k < NN; k++) exp_q.push_back(golden(k));
            drive_frame();
            wait_frame($sformatf("rand%0d", r));
        end

        // Back-pressure on the first SEND
        load_vec(0);
        base = clear_cnt;
        drive_frame();
        wait_state("bp", S_LATCH, base + 1);
        bp_skip = 1;
        tx_busy = 1'b1;
        st = start_total;
        repeat (50) @(posedge clk);
        #1;
        check("bp_hold_state", {61'd0, dbg_state}, {61'd0, S_SEND});
        check("bp_no_early_start", 64'(start_total), 64'(st));
        tx_busy = 1'b0;
        @(negedge clk);
        check("bp_start_after_release", {63'd0, tx_start}, 64'd1);
        wait_frame("bp");

        // Overrun during neuron 1 ISSUE
        load_vec(0);
        base = clear_cnt;
        drive_frame();
        check("overrun_clear_before", {63'd0, rx_overrun}, 64'd0);
        wait_state("ovr", S_ISSUE, base + 2);
        rx_done = 1'b1;
        rx_data = 8'h55;
        @(posedge clk); #1;
        rx_done = 1'b0;
        @(negedge clk);
        check("overrun_set", {63'd0, rx_overrun}, 64'd1);
        wait_frame("ovr");
        load_vec(2);
        drive_frame();
        wait_frame("after_ovr");
        check("overrun_sticky", {63'd0, rx_overrun}, 64'd1);

        // Reset mid-pass during neuron 2 ISSUE
        load_vec(0);
        base = clear_cnt;
        drive_frame();
        wait_state("rst", S_ISSUE, base + 3);
        repeat (3) begin @(posedge clk); #1; end
        #2;
        reset = 1'b1;
        #1;
        check("reset_async_outputs", {23'd0, all_outs}, 64'd0);
        exp_q.delete();
        clear_seen = 0;
        starts_in_frame = 0;
        st = start_total;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        check("abort_no_start", 64'(start_total), 64'(st));
        load_vec(0);
        drive_frame();
        wait_frame("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/neuron_scheduler.md
# neuron_scheduler

Sequences one inference pass of the fully-connected layer once weights are resident. It buffers an input vector of N_INPUTS signed bytes from the UART receiver. For each neuron it streams (input, weight) pairs from the weight RAM into the shared MAC unit, then saturates the accumulator to one signed byte and hands it to the UART transmitter. It sits between the UART RX/TX, the weight RAM read port and the MAC, and replaces the free-running RX→MAC→TX path.

## Interface
- N_NEURONS, 4: neurons per pass; weight RAM holds N_NEURONS*N_INPUTS bytes, neuron-major.
- N_INPUTS, 16: bytes per input vector.
- ADDR_W, 8: weight RAM address width; N_NEURONS*N_INPUTS ≤ 2^ADDR_W.
- ACC_W, 20: MAC accumulator width, signed.
- SHIFT, 4: arithmetic right shift applied to the accumulator before saturation.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; all state cleared immediately.
- weights_ready  in  1  level from weight-load controller; sampled only in IDLE.
- rx_done  in  1  one-cycle strobe, rx_data valid.
- rx_data  in  8  received byte, signed.
- w_rd_addr  out  ADDR_W  weight RAM read address; synchronous RAM, data one cycle later.
- w_rd_data  in  8  weight byte, signed.
- mac_clear  out  1  one-cycle pulse, MAC accumulator ← 0.
- mac_valid  out  1  MAC accumulates mac_a*mac_b on this edge.
- mac_a  out  8  input operand.
- mac_b  out  8  weight operand.
- mac_acc  in  ACC_W  registered MAC result.
- tx_start  out  1  one-cycle pulse, send tx_data.
- tx_data  out  8  saturated neuron output.
- tx_busy  in  1  transmitter busy.
- busy  out  1  high in every state except IDLE and COLLECT.
- frame_done  out  1  one-cycle pulse after last neuron's byte is launched.
- rx_overrun  out  1  sticky; set when rx_done arrives while busy; cleared only by reset.

## Operation
- Reset values: state IDLE; all outputs 0; w_rd_addr 0; input count 0; neuron index 0. Input buffer contents are undefined.
- IDLE: if weights_ready, go to COLLECT. rx_done is ignored and does not set rx_overrun.
- COLLECT: each rx_done writes rx_data to buf[cnt] and increments cnt. On the N_INPUTS-th byte, go to CLEAR with n=0.
- CLEAR: mac_clear=1 for one cycle; i=0; go to ISSUE.
- ISSUE: drive w_rd_addr = n*N_INPUTS + i for N_INPUTS consecutive cycles.
  - On the following cycle, mac_valid=1, mac_a=buf[i] (delayed one cycle), mac_b=w_rd_data.
  - After the last address, go to DRAIN.
- DRAIN: one cycle to issue the final mac_valid. Then LATCH.
- LATCH: mac_acc is final. Compute r = mac_acc >>> SHIFT (signed); clamp r to [-128, 127]; register it into tx_data. Go to SEND.
- SEND: wait while tx_busy=1. When tx_busy=0, pulse tx_start and go to GAP.
- GAP: one cycle in which tx_busy is ignored (the transmitter's busy flag rises late).
  - If n < N_NEURONS-1: n++, go to CLEAR.
  - Else: pulse frame_done, set cnt=0, go to COLLECT (weights stay valid).
- rx_done while busy=1: the byte is dropped and rx_overrun←1. buf is not modified.
- rx_done coincident with the cycle that returns to COLLECT: the byte is dropped and rx_overrun is set (busy is still 1 that cycle).
- weights_ready falling outside IDLE has no effect.

## Timing
- Let CLEAR be cycle c:
  - ISSUE runs c+1..c+N_INPUTS.
  - mac_valid runs c+2..c+N_INPUTS+1 (DRAIN is c+N_INPUTS+1).
  - LATCH is c+N_INPUTS+2.
  - Earliest tx_start is c+N_INPUTS+3.
- With tx_busy held 0, one neuron takes N_INPUTS+5 cycles, CLEAR to CLEAR (21 at defaults).
- Last input byte strobe at cycle t puts CLEAR at t+1.
- mac_clear and mac_valid are never high in the same cycle.
- tx_start is never asserted while tx_busy=1.
- Reset asserted mid-pass aborts immediately: no tx_start, no frame_done; returns to IDLE.

## Test plan
- Basic frame: inputs all 1, weights for neuron k all k+1 (k=0..3), acc=16(k+1) → tx_data sequence 1,2,3,4 (SHIFT 4). frame_done pulses once, 1 cycle after the 4th tx_start.
- Saturation: inputs 127, weights 127 → acc=258064 → clamp 127. Inputs 127, weights -128 → acc=-260096 → clamp -128. Acc=-17 → -17>>>4 = -2.
- Back-pressure: hold tx_busy=1 for 50 cycles at first SEND → tx_start is delayed to the cycle after tx_busy falls; results unchanged; no duplicate pulses.
- Overrun: inject rx_done during ISSUE of neuron 1 → rx_overrun=1 and stays 1; outputs identical to the no-injection run. The next frame collects correctly from cnt=0.
- Gating: weights_ready=0 with 16 rx_done strobes → stays IDLE, no MAC activity, rx_overrun=0. Raise weights_ready → 16 new bytes produce a normal frame.
- Reset mid-pass: assert reset during neuron 2 ISSUE → all outputs 0 asynchronously. After release, a full frame reproduces the golden bytes.
